// File: rtl/clock_pkg.sv
// Shared constants, state encoding and time payload for the clock-display datapath.
package clock_pkg;

    localparam int unsigned KILO    = 1000;
    localparam int unsigned MS_MAX  = 999;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    localparam int unsigned MS_W  = 10;
    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RUNNING = ST_RUNNING,
        PAUSED  = ST_PAUSED,
        EXPIRED = ST_EXPIRED
    } timer_state_t;

    // minutes:seconds:milliseconds as carried on the display bus
    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms;
    } time_t;

    function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v);
        return (v > MS_W'(MS_MAX)) ? MS_W'(MS_MAX) : v;
    endfunction

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] v);
        return (v > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : v;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
        return (v > MIN_W'(MIN_MAX)) ? MIN_W'(MIN_MAX) : v;
    endfunction

endpackage

// File: rtl/PosedgeDetector.sv
// Rising-edge detector: flags the cycle in which sig is first sampled high.
module PosedgeDetector (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise_c
);

    logic sig_q;

    // previous-value register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/tick_divider.sv
// Enable-tick generator: one-cycle tick every DIV clocks, held cleared while clear is high.
module tick_divider #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // tick fires on the last count of each period; a clear suppresses it
    assign tick = ~clear & (cnt == LAST);

    // period counter, restarting after each tick or on clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Millisecond-resolution min:sec:ms countdown timer with pause/resume and expiry alarm.
module countdown_timer
    import clock_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = KILO
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic [MS_W-1:0]  set_ms,
    input  logic [SEC_W-1:0] set_sec,
    input  logic [MIN_W-1:0] set_min,
    output logic [MS_W-1:0]  ms_out,
    output logic [SEC_W-1:0] sec_out,
    output logic [MIN_W-1:0] min_out,
    output logic             running,
    output logic             done,
    output logic             alarm
);

    localparam int unsigned DIV = CLK_FREQ_HZ / KILO;

    timer_state_t state;
    time_t        cnt_q;
    time_t        preset_c;
    time_t        dec_c;
    logic         start_rise_c;
    logic         stop_rise_c;
    logic         tick_c;
    logic         div_clear_c;
    logic         is_zero_c;
    logic         is_one_c;

    PosedgeDetector u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (start),
        .rise_c  (start_rise_c)
    );

    PosedgeDetector u_stop_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (stop),
        .rise_c  (stop_rise_c)
    );

    // divider only runs while counting; a load restarts it as well
    assign div_clear_c = (state != RUNNING) | load;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (div_clear_c),
        .tick    (tick_c)
    );

    // clamped preset and zero / last-millisecond detection
    always_comb begin
        preset_c.min = clamp_min(set_min);
        preset_c.sec = clamp_sec(set_sec);
        preset_c.ms  = clamp_ms(set_ms);
        is_zero_c    = (cnt_q.min == '0) && (cnt_q.sec == '0) && (cnt_q.ms == '0);
        is_one_c     = (cnt_q.min == '0) && (cnt_q.sec == '0) && (cnt_q.ms == MS_W'(1));
    end

    // one-millisecond decrement with ms -> sec -> min borrow
    always_comb begin
        dec_c = cnt_q;
        if (cnt_q.ms != '0) begin
            dec_c.ms = cnt_q.ms - MS_W'(1);
        end else begin
            dec_c.ms = MS_W'(MS_MAX);
            if (cnt_q.sec != '0) begin
                dec_c.sec = cnt_q.sec - SEC_W'(1);
            end else begin
                dec_c.sec = SEC_W'(SEC_MAX);
                dec_c.min = cnt_q.min - MIN_W'(1);
            end
        end
    end

    // control FSM with registered time, running, done and alarm
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt_q   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt_q   <= preset_c;
                state   <= IDLE;
                running <= 1'b0;
                alarm   <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSED: begin
                        // a simultaneous stop edge overrides start
                        if (start_rise_c && !stop_rise_c && !is_zero_c) begin
                            state   <= RUNNING;
                            running <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        if (stop_rise_c) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (tick_c) begin
                            cnt_q <= dec_c;
                            if (is_one_c) begin
                                state   <= EXPIRED;
                                running <= 1'b0;
                                alarm   <= 1'b1;
                                done    <= 1'b1;
                            end
                        end
                    end
                    EXPIRED: begin
                        state <= EXPIRED;
                    end
                endcase
            end
        end
    end

    assign ms_out  = cnt_q.ms;
    assign sec_out = cnt_q.sec;
    assign min_out = cnt_q.min;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer at 1 kHz and 4 kHz clocks.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic       start;
    logic       stop;
    logic [9:0] set_ms;
    logic [5:0] set_sec;
    logic [5:0] set_min;

    logic [9:0] ms1, ms4;
    logic [5:0] sec1, sec4, min1, min4;
    logic       running1, running4, done1, done4, alarm1, alarm4;

    int checks = 0;
    int errors = 0;

    // reference model: remaining time in plain milliseconds
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int unsigned m_rem[2];
    int          m_state[2];
    int unsigned m_phase[2];
    bit          m_done[2];
    bit          m_prev_start;
    bit          m_prev_stop;

    always #5 clk = ~clk;

    countdown_timer #(.CLK_FREQ_HZ(1000)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .start   (start),
        .stop    (stop),
        .set_ms  (set_ms),
        .set_sec (set_sec),
        .set_min (set_min),
        .ms_out  (ms1),
        .sec_out (sec1),
        .min_out (min1),
        .running (running1),
        .done    (done1),
        .alarm   (alarm1)
    );

    countdown_timer #(.CLK_FREQ_HZ(4000)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .start   (start),
        .stop    (stop),
        .set_ms  (set_ms),
        .set_sec (set_sec),
        .set_min (set_min),
        .ms_out  (ms4),
        .sec_out (sec4),
        .min_out (min4),
        .running (running4),
        .done    (done4),
        .alarm   (alarm4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rem[d]   = 0;
            m_state[d] = M_IDLE;
            m_phase[d] = 0;
            m_done[d]  = 1'b0;
        end
        m_prev_start = 1'b0;
        m_prev_stop  = 1'b0;
    endtask

    function automatic int unsigned preset_ms();
        int unsigned mn, sc, ms;
        mn = (set_min > 59) ? 59 : int'(set_min);
        sc = (set_sec > 59) ? 59 : int'(set_sec);
        ms = (set_ms > 999) ? 999 : int'(set_ms);
        return mn * 60000 + sc * 1000 + ms;
    endfunction

    // one clock of the reference model, using the inputs sampled at this edge
    task automatic model_step();
        bit rs, rp;
        int unsigned div;
        if (!reset_n) begin
            model_reset();
            return;
        end
        rs = start && !m_prev_start;
        rp = stop && !m_prev_stop;
        m_prev_start = start;
        m_prev_stop  = stop;
        for (int d = 0; d < 2; d++) begin
            div = (d == 0) ? 1 : 4;
            m_done[d] = 1'b0;
            if (load) begin
                m_rem[d]   = preset_ms();
                m_state[d] = M_IDLE;
                m_phase[d] = 0;
            end else if (m_state[d] == M_IDLE || m_state[d] == M_PAUSE) begin
                if (rs && !rp && m_rem[d] != 0) begin
                    m_state[d] = M_RUN;
                    m_phase[d] = 0;
                end
            end else if (m_state[d] == M_RUN) begin
                if (rp) begin
                    m_state[d] = M_PAUSE;
                end else begin
                    m_phase[d]++;
                    if (m_phase[d] == div) begin
                        m_phase[d] = 0;
                        m_rem[d]--;
                        if (m_rem[d] == 0) begin
                            m_state[d] = M_EXP;
                            m_done[d]  = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_one(input int d, input string nm, input logic [9:0] ms,
                               input logic [5:0] sec, input logic [5:0] mn,
                               input logic run, input logic dn, input logic al);
        check({nm, " ms"},      32'(ms),  m_rem[d] % 1000);
        check({nm, " sec"},     32'(sec), (m_rem[d] / 1000) % 60);
        check({nm, " min"},     32'(mn),  m_rem[d] / 60000);
        check({nm, " running"}, 32'(run), 32'(m_state[d] == M_RUN));
        check({nm, " done"},    32'(dn),  32'(m_done[d]));
        check({nm, " alarm"},   32'(al),  32'(m_state[d] == M_EXP));
    endtask

    task automatic compare_all();
        compare_one(0, "div1", ms1, sec1, min1, running1, done1, alarm1);
        compare_one(1, "div4", ms4, sec4, min4, running4, done4, alarm4);
    endtask

    // inputs are driven at the falling edge; outputs compared at the next falling edge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_load(input int mn, input int sc, input int ms);
        load    = 1'b1;
        set_min = 6'(mn);
        set_sec = 6'(sc);
        set_ms  = 10'(ms);
        step();
        load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        set_ms  = '0;
        set_sec = '0;
        set_min = '0;
        model_reset();

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("reset ms", 32'(ms1), 0);
        check("reset sec", 32'(sec1), 0);
        check("reset min", 32'(min1), 0);
        check("reset running", 32'(running1), 0);
        check("reset alarm", 32'(alarm1), 0);
        check("reset done", 32'(done1), 0);
        compare_all();
        reset_n = 1'b1;
        step();

        // load 1:02:003
        do_load(1, 2, 3);
        check("load min", 32'(min1), 1);
        check("load sec", 32'(sec1), 2);
        check("load ms", 32'(ms1), 3);
        check("load running", 32'(running1), 0);
        step();

        // clamp 63:63:1023 -> 59:59:999
        do_load(63, 63, 1023);
        check("clamp min", 32'(min4), 59);
        check("clamp sec", 32'(sec4), 59);
        check("clamp ms", 32'(ms1), 999);

        // start at zero is ignored
        do_load(0, 0, 0);
        step();
        start = 1'b1;
        step();
        check("zero start running", 32'(running1), 0);
        start = 1'b0;
        step();

        // pause/resume at DIV=4
        do_load(0, 0, 10);
        start = 1'b1;
        step();
        check("pr running", 32'(running4), 1);
        start = 1'b0;
        repeat (8) step();
        check("pr ms before stop", 32'(ms4), 8);
        stop = 1'b1;
        step();
        check("pr ms at stop", 32'(ms4), 8);
        stop = 1'b0;
        repeat (3) step();
        check("pr ms held", 32'(ms4), 8);
        start = 1'b1;
        stop  = 1'b1;
        step();
        check("pr both edges", 32'(running4), 0);
        start = 1'b0;
        stop  = 1'b0;
        step();
        start = 1'b1;
        step();
        check("pr resumed", 32'(running4), 1);
        repeat (3) step();
        check("pr no early dec", 32'(ms4), 8);
        step();
        check("pr dec after div", 32'(ms4), 7);
        repeat (5) step();

        // load while running
        do_load(0, 5, 0);
        check("run load running", 32'(running4), 0);
        check("run load sec", 32'(sec4), 5);
        check("run load alarm", 32'(alarm4), 0);
        start = 1'b0;
        step();

        // full borrow chain from 1:00:000
        do_load(1, 0, 0);
        start = 1'b1;
        step();
        step();
        check("borrow min", 32'(min1), 0);
        check("borrow sec", 32'(sec1), 59);
        check("borrow ms", 32'(ms1), 999);
        start = 1'b0;
        repeat (59998) step();
        step();
        check("expire done", 32'(done1), 1);
        check("expire alarm", 32'(alarm1), 1);
        check("expire ms", 32'(ms1), 0);
        check("expire sec", 32'(sec1), 0);
        check("expire running", 32'(running1), 0);
        start = 1'b1;
        step();
        check("expire done once", 32'(done1), 0);
        check("expire alarm held", 32'(alarm1), 1);
        start = 1'b0;
        do_load(0, 0, 2);
        check("alarm cleared", 32'(alarm1), 0);

        // asynchronous reset mid-run
        do_load(0, 0, 500);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        #2 reset_n = 1'b0;
        #1;
        check("async ms", 32'(ms1), 0);
        check("async running", 32'(running1), 0);
        check("async ms4", 32'(ms4), 0);
        check("async running4", 32'(running4), 0);
        step();
        reset_n = 1'b1;
        step();

        // randomized traffic with mostly short presets so expiry is reached
        for (int i = 0; i < 4000; i++) begin
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 11) == 0) stop = ~stop;
            if ($urandom_range(0, 15) == 0) begin
                set_ms  = 10'($urandom);
                set_sec = 6'($urandom);
                set_min = 6'($urandom);
            end else begin
                set_ms  = 10'($urandom_range(0, 40));
                set_sec = 6'($urandom_range(0, 1));
                set_min = 6'(0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Counts a loaded minutes:seconds:milliseconds value down to zero at 1 ms resolution and raises an alarm on expiry. It is the down-counting counterpart of the stopwatch in the clock-display datapath, driving the same ms/sec/min display format. It uses one clock domain: the millisecond rate comes from an internal enable tick, not a derived clock.

## Interface
- CLK_FREQ_HZ, default `KILO (1000): input clock frequency. Must be ≥1000 and an integer multiple of 1000.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  level; while high, preset registers take set_* values (clamped)
- start  in  1  rising edge starts or resumes the countdown
- stop  in  1  rising edge pauses the countdown
- set_ms  in  10  preset milliseconds; values >999 clamp to 999
- set_sec  in  6  preset seconds; values >59 clamp to 59
- set_min  in  6  preset minutes; values >59 clamp to 59
- ms_out  out  10  remaining milliseconds, 0..999
- sec_out  out  6  remaining seconds, 0..59
- min_out  out  6  remaining minutes, 0..59
- running  out  1  high in RUNNING
- done  out  1  one-clk pulse on reaching zero
- alarm  out  1  level, high in EXPIRED

## Operation
- DIV = CLK_FREQ_HZ/1000. An internal counter produces `tick` once every DIV clk cycles; it is held cleared outside RUNNING.
- start and stop each pass through a posedge detector (previous-value register). An edge is detected in the cycle the input is first sampled high.
- States:
  - IDLE: reset and post-load state.
  - RUNNING: counting.
  - PAUSED: counting suspended.
  - EXPIRED: time reached zero.
- Per-cycle priority: load > stop edge > start edge > tick.
  - load (any state): outputs ← clamped set_*; state → IDLE; alarm cleared; divider cleared.
  - start edge in IDLE/PAUSED: if outputs ≠ 0:0:000 → RUNNING, else ignored (stays put). Ignored in RUNNING and EXPIRED.
  - stop edge in RUNNING → PAUSED. Ignored in other states.
  - Simultaneous start and stop edges: stop wins.
- Tick in RUNNING decrements with borrow:
  - ms>0: ms−1.
  - ms==0: ms←999 and borrow from sec; sec==0 → sec←59, borrow from min.
- Decrement from 0:0:001 → 0:0:000 moves the state to EXPIRED and asserts done for exactly that one cycle.
- Outputs never wrap below zero. EXPIRED holds 0:0:000 until load or reset.
- Reset (reset_n low, async): all outputs 0, state IDLE, divider and edge-detector registers 0.

## Timing
- All state and outputs update on posedge clk; reset acts immediately.
- Start latency: the start edge seen at edge N sets running at edge N. The first decrement lands at edge N+DIV, then one every DIV cycles.
- Pause/resume: the divider clears on pause, so each resume costs a full DIV before the next decrement.
- done, running and alarm are registered and change on the same edge as the final count.
- From preset T ms, expiry occurs exactly T·DIV cycles after RUNNING entry, with no pauses.
- Load takes effect on the edge it is sampled. With load held high, outputs track set_* every cycle.

## Structure
- Shared package (clock_pkg):
  - `KILO.
  - MS_MAX=999, SEC_MAX=59, MIN_MAX=59.
  - State encoding localparams (IDLE, RUNNING, PAUSED, EXPIRED).
- Sub-module `tick_divider` (params DIV; ports clk, reset_n, clear, tick). Reused by future same-domain timers.
- Posedge detection reuses the existing PosedgeDetector.

## Test plan
- Reset/load (CLK_FREQ_HZ=1000, DIV=1): reset_n low → outputs 0:0:000, running=0, alarm=0. Load 1:02:003 → outputs 1:02:003, IDLE.
- Borrow chain: load 1:00:000, start. After 1 cycle → 0:59:999. After 60000 cycles total → done pulse, alarm=1, 0:0:000.
- Clamp: set 63:63:1023 with load → 59:59:999.
- Pause/resume (CLK_FREQ_HZ=4000): load 0:0:010, start. Stop after 8 cycles → 0:0:008 and held. Restart → next decrement exactly 4 cycles later.
- Edge cases:
  - start at 0:0:000 → stays IDLE.
  - start and stop rise together while PAUSED → stays PAUSED.
  - start held high keeps counting but triggers nothing new.
- Load and reset mid-run:
  - load during RUNNING → IDLE with the new value, alarm cleared.
  - reset_n pulse mid-run → all outputs 0 immediately, async.
